tft_capture: RTL



---
 rtl/tft_capture.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tft_capture.sv
// TFT video capture front end.
// Watches an RGB565 parallel video stream (vsync / data-enable framing) and
// turns one frame, or a continuous run of frames, into frame-buffer writes
// with linear addresses. It also reports the geometry of the last frame and
// whether that frame matched the expected H_ACTIVE x V_ACTIVE raster.
module tft_capture #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int ADDR_W   = 17
) (
    input  logic              clk_ctrl,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cont_mode,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic [15:0]       vid_rgb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy,
    output logic [11:0]       last_width,
    output logic [11:0]       last_height,
    output logic              line_err,
    output logic              frame_err
);

    // Capture state encoding.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    // Raster limits at counter width, so every compare is 12 bits wide.
    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

    // Per-line address step.
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    // Address adder width: wide enough for both line_base and the x counter.
    localparam int SUM_W = (ADDR_W > 12) ? ADDR_W : 12;

    // The whole active raster has to be addressable.
    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_size_check
        $error("tft_capture: H_ACTIVE*V_ACTIVE does not fit in ADDR_W bits");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_vs_d;
    logic              r_de_d;
    logic              w_fe;
    logic              w_in_cap;
    logic              w_pix;
    logic              w_de_fall;
    logic              w_start;
    logic              w_frame_end;
    logic              w_clear;
    logic [11:0]       r_x;
    logic [11:0]       r_y;
    logic [11:0]       r_line_w;
    logic              r_err_acc;
    logic [ADDR_W-1:0] r_line_base;
    logic [SUM_W-1:0]  w_addr_sum;
    logic              w_hs_unused;

    // Counters stop at their maximum instead of wrapping, so an absurdly
    // long line or frame still reports a large (clearly wrong) size.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // A pixel is stored only if it lands inside the expected raster;
    // overlong lines and surplus lines are counted but never written.
    function automatic logic in_window(input logic [11:0] x, input logic [11:0] y);
        return (x < H_LIM) && (y < V_LIM);
    endfunction

    // Line boundaries come from data-enable alone; hsync carries no
    // information this block needs.
    assign w_hs_unused = vid_hs;

    // Frame edge is the rising edge of vsync, i.e. the end of the sync pulse.
    assign w_fe        = vid_vs & ~r_vs_d;
    assign w_in_cap    = (r_state == S_CAPTURE);

    // A frame edge wins over a coincident pixel or line end: that pixel is
    // dropped and whatever follows belongs to the next frame.
    assign w_pix       = w_in_cap & vid_de & ~w_fe;
    assign w_de_fall   = w_in_cap & r_de_d & ~vid_de & ~w_fe;

    assign w_frame_end = w_in_cap & w_fe;
    assign w_start     = w_fe & (w_state_nxt == S_CAPTURE);

    // Any frame edge seen while waiting for or capturing a frame restarts the
    // per-frame bookkeeping; the finished frame has already been latched.
    assign w_clear     = w_fe & (r_state != S_IDLE);

    assign w_addr_sum  = SUM_W'(r_line_base) + SUM_W'(r_x);

    // Next-state logic: arm on request, start on a frame edge, and either
    // roll straight into the next frame or stop at the end of this one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (capture_en) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_fe) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_fe) begin
                    w_state_nxt = (capture_en && cont_mode) ? S_CAPTURE : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sync/enable delay taps, FSM state, and the busy flag that mirrors it.
    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_state <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            r_vs_d  <= vid_vs;
            r_de_d  <= vid_de;
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Raster position, line base address, last line width and error flag.
    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            r_x         <= 12'd0;
            r_y         <= 12'd0;
            r_line_w    <= 12'd0;
            r_err_acc   <= 1'b0;
            r_line_base <= '0;
        end else if (w_clear) begin
            r_x         <= 12'd0;
            r_y         <= 12'd0;
            r_err_acc   <= 1'b0;
            r_line_base <= '0;
        end else if (w_pix) begin
            r_x <= sat_inc(r_x);
        end else if (w_de_fall) begin
            r_line_w    <= r_x;
            r_err_acc   <= r_err_acc | (r_x != H_LIM);
            r_y         <= sat_inc(r_y);
            r_line_base <= r_line_base + H_STEP;
            r_x         <= 12'd0;
        end
    end

    // Frame-buffer write port: one registered write per in-window pixel.
    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 16'd0;
        end else begin
            wr_en <= 1'b0;
            if (w_pix) begin
                wr_en   <= in_window(r_x, r_y);
                wr_addr <= w_addr_sum[ADDR_W-1:0];
                wr_data <= vid_rgb;
            end
        end
    end

    // Frame pulses and the geometry report, held until the next frame ends.
    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            last_width  <= 12'd0;
            last_height <= 12'd0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_start <= w_start;
            frame_done  <= w_frame_end;
            if (w_frame_end) begin
                last_height <= r_y;
                last_width  <= r_line_w;
                line_err    <= r_err_acc;
                frame_err   <= (r_y != V_LIM);
            end
        end
    end

endmodule
